// File: rtl/acc_sequencer.sv
// acc_sequencer: multi-cycle fetch/decode/execute controller in front of the team ALU.
// Owns PC, instruction register and accumulator; fetches from a synchronous-read
// program memory and emits values through a valid/ready output port.
//
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-high reset
//   Start                begin execution at PC=0 (sampled only in IDLE/HALTED)
//   Busy, Halted         status flags
//   ProgAddr, ProgData   program memory address (=PC) / instruction word {Op, Imm}
//   AluA, AluB,
//   AluOpcode, AluResult ALU operand/opcode drive and combinational result
//   OutData, OutValid,
//   OutReady             output port, transfer on OutValid && OutReady
//   AccOut               accumulator visibility
module acc_sequencer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    output logic                  Busy,
    output logic                  Halted,
    output logic [ADDR_WIDTH-1:0] ProgAddr,
    input  logic [WIDTH+3:0]      ProgData,
    output logic [WIDTH-1:0]      AluA,
    output logic [WIDTH-1:0]      AluB,
    output logic [3:0]            AluOpcode,
    input  logic [WIDTH-1:0]      AluResult,
    output logic [WIDTH-1:0]      OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [WIDTH-1:0]      AccOut
);

    localparam int unsigned IR_WIDTH = WIDTH + 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SHL  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SHR  = 4'h3;
    localparam logic [3:0] OP_LDI  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU opcode whose result is 0; driven whenever the ALU is not in use.
    localparam logic [3:0] ALU_IDLE = 4'b0100;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        OUTPUT  = 3'd4,
        HALTED  = 3'd5
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pc_n;
    logic [IR_WIDTH-1:0]   ir, ir_n;
    logic [WIDTH-1:0]      acc, acc_n;
    logic [WIDTH-1:0]      out_data, out_data_n;
    logic                  out_valid, out_valid_n;
    logic [WIDTH-1:0]      alu_b, alu_b_n;
    logic [3:0]            alu_op, alu_op_n;
    logic                  busy, busy_n;
    logic                  halted, halted_n;

    logic [3:0]       ir_op, pd_op;
    logic [WIDTH-1:0] ir_imm, pd_imm;

    assign ir_op  = ir[IR_WIDTH-1:WIDTH];
    assign ir_imm = ir[WIDTH-1:0];
    assign pd_op  = ProgData[IR_WIDTH-1:WIDTH];
    assign pd_imm = ProgData[WIDTH-1:0];

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            alu_b     <= '0;
            alu_op    <= ALU_IDLE;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir        <= ir_n;
            acc       <= acc_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            alu_b     <= alu_b_n;
            alu_op    <= alu_op_n;
            busy      <= busy_n;
            halted    <= halted_n;
        end
    end

    // Next-state, datapath update and registered-output preparation.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ir_n        = ir;
        acc_n       = acc;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        alu_b_n     = '0;
        alu_op_n    = ALU_IDLE;

        case (state)
            IDLE, HALTED: begin
                if (Start) begin
                    state_n = FETCH;
                    pc_n    = '0;
                    acc_n   = '0;
                end
            end
            FETCH: state_n = DECODE;
            DECODE: begin
                ir_n    = ProgData;
                state_n = EXECUTE;
                // ALU drive is registered, so it is set up from the word being latched.
                case (pd_op)
                    OP_ADD, OP_SUB: begin
                        alu_b_n  = pd_imm;
                        alu_op_n = pd_op;
                    end
                    OP_SHL, OP_SHR: begin
                        alu_b_n  = acc;
                        alu_op_n = pd_op;
                    end
                    default: ;
                endcase
            end
            EXECUTE: begin
                state_n = FETCH;
                pc_n    = pc + ADDR_WIDTH'(1);
                case (ir_op)
                    OP_ADD, OP_SHL, OP_SUB, OP_SHR: acc_n = AluResult;
                    OP_LDI: acc_n = ir_imm;
                    OP_JMP: pc_n = ir_imm[ADDR_WIDTH-1:0];
                    OP_JZ: begin
                        if (acc == '0) pc_n = ir_imm[ADDR_WIDTH-1:0];
                    end
                    OP_OUT: begin
                        // PC advances only once the value has been accepted.
                        pc_n        = pc;
                        out_data_n  = acc;
                        out_valid_n = 1'b1;
                        state_n     = OUTPUT;
                    end
                    OP_HALT: begin
                        pc_n    = pc;
                        state_n = HALTED;
                    end
                    default: ;
                endcase
            end
            OUTPUT: begin
                if (out_valid && OutReady) begin
                    out_valid_n = 1'b0;
                    pc_n        = pc + ADDR_WIDTH'(1);
                    state_n     = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n   = (state_n == FETCH) || (state_n == DECODE) ||
                   (state_n == EXECUTE) || (state_n == OUTPUT);
        halted_n = (state_n == HALTED);
    end

    assign Busy      = busy;
    assign Halted    = halted;
    assign ProgAddr  = pc;
    assign AluA      = acc;
    assign AluB      = alu_b;
    assign AluOpcode = alu_op;
    assign OutData   = out_data;
    assign OutValid  = out_valid;
    assign AccOut    = acc;

endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: directed self-checking bench for acc_sequencer with a
// behavioural ALU and a synchronous-read program memory.
module tb_acc_sequencer;

    localparam int unsigned WIDTH      = 4;
    localparam int unsigned ADDR_WIDTH = 4;

    logic                  Clock = 1'b0;
    logic                  Reset;
    logic                  Start;
    logic                  Busy;
    logic                  Halted;
    logic [ADDR_WIDTH-1:0] ProgAddr;
    logic [WIDTH+3:0]      ProgData;
    logic [WIDTH-1:0]      AluA;
    logic [WIDTH-1:0]      AluB;
    logic [3:0]            AluOpcode;
    logic [WIDTH-1:0]      AluResult;
    logic [WIDTH-1:0]      OutData;
    logic                  OutValid;
    logic                  OutReady;
    logic [WIDTH-1:0]      AccOut;

    logic [WIDTH+3:0] mem [16];

    int checks   = 0;
    int failures = 0;

    acc_sequencer #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Busy      (Busy),
        .Halted    (Halted),
        .ProgAddr  (ProgAddr),
        .ProgData  (ProgData),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluOpcode (AluOpcode),
        .AluResult (AluResult),
        .OutData   (OutData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .AccOut    (AccOut)
    );

    always #5 Clock = ~Clock;

    // Synchronous-read program memory.
    always @(posedge Clock) ProgData <= mem[ProgAddr];

    // Team ALU behaviour.
    always_comb begin
        case (AluOpcode)
            4'b0000: AluResult = AluA + AluB;
            4'b0001: AluResult = AluB << 1;
            4'b0010: AluResult = AluA - AluB;
            4'b0011: AluResult = AluB >> 1;
            default: AluResult = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Steps until Halted; cyc is the cycle index (0 = first cycle after Start) at which it is seen.
    task automatic run_until_halt(output int cyc, output int nvalid, output logic [WIDTH-1:0] last);
        cyc    = 0;
        nvalid = 0;
        last   = '0;
        while (!Halted && cyc < 400) begin
            if (OutValid) begin
                nvalid++;
                last = OutData;
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               cyc, nv, bad, nch;
        logic [WIDTH-1:0] last, prev;
        logic [3:0]       op_tr  [16];
        logic [3:0]       acc_tr [16];
        logic [3:0]       b_tr   [16];
        logic             hlt_tr [16];
        logic [3:0]       pa_tr  [52];
        logic [31:0]      ch     [8];

        Reset    = 1'b1;
        Start    = 1'b0;
        OutReady = 1'b1;
        fill(8'h00);
        tick();
        tick();
        Reset = 1'b0;
        repeat (5) tick();
        check("rst_busy",   32'(Busy),      32'd0);
        check("rst_halted", 32'(Halted),    32'd0);
        check("rst_valid",  32'(OutValid),  32'd0);
        check("rst_addr",   32'(ProgAddr),  32'd0);
        check("rst_acc",    32'(AccOut),    32'd0);
        check("rst_aluop",  32'(AluOpcode), 32'h4);

        // LDI 5, ADD 3, OUT, HALT; run twice.
        fill(8'h80);
        mem[0] = 8'h45; mem[1] = 8'h03; mem[2] = 8'h70; mem[3] = 8'hF0;
        for (int r = 0; r < 2; r++) begin
            start_pulse();
            run_until_halt(cyc, nv, last);
            check($sformatf("p1_cycles_r%0d", r), 32'(cyc),      32'd13);
            check($sformatf("p1_nvalid_r%0d", r), 32'(nv),       32'd1);
            check($sformatf("p1_data_r%0d", r),   32'(last),     32'd8);
            check($sformatf("p1_addr_r%0d", r),   32'(ProgAddr), 32'd3);
            check($sformatf("p1_acc_r%0d", r),    32'(AccOut),   32'd8);
            tick();
            check($sformatf("p1_halt_r%0d", r),   32'(Halted),   32'd1);
        end

        // LDI 2, SUB 3, SHR, SHL, HALT: trace ALU opcode/operand and accumulator.
        fill(8'h80);
        mem[0] = 8'h42; mem[1] = 8'h23; mem[2] = 8'h30; mem[3] = 8'h10; mem[4] = 8'hF0;
        start_pulse();
        for (int c = 0; c < 16; c++) begin
            op_tr[c]  = AluOpcode;
            acc_tr[c] = AccOut;
            b_tr[c]   = AluB;
            hlt_tr[c] = Halted;
            tick();
        end
        check("p2_op_ldi",   32'(op_tr[2]),   32'h4);
        check("p2_acc_ldi",  32'(acc_tr[3]),  32'h2);
        check("p2_op_dec",   32'(op_tr[4]),   32'h4);
        check("p2_op_sub",   32'(op_tr[5]),   32'h2);
        check("p2_b_sub",    32'(b_tr[5]),    32'h3);
        check("p2_acc_sub",  32'(acc_tr[6]),  32'hF);
        check("p2_op_shr",   32'(op_tr[8]),   32'h3);
        check("p2_b_shr",    32'(b_tr[8]),    32'hF);
        check("p2_acc_shr",  32'(acc_tr[9]),  32'h7);
        check("p2_op_shl",   32'(op_tr[11]),  32'h1);
        check("p2_b_shl",    32'(b_tr[11]),   32'h7);
        check("p2_acc_shl",  32'(acc_tr[12]), 32'hE);
        check("p2_not_halt", 32'(hlt_tr[14]), 32'd0);
        check("p2_halt",     32'(hlt_tr[15]), 32'd1);

        // LDI 9, OUT, HALT with consumer stalling 6 cycles.
        fill(8'h80);
        mem[0] = 8'h49; mem[1] = 8'h70; mem[2] = 8'hF0;
        start_pulse();
        nv  = 0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            OutReady = (c >= 12);
            if (OutValid) begin
                nv++;
                if (OutData !== 4'd9) bad++;
                if (ProgAddr !== 4'd1) bad++;
            end
            tick();
        end
        OutReady = 1'b1;
        check("p3_nvalid", 32'(nv),       32'd7);
        check("p3_stable", 32'(bad),      32'd0);
        check("p3_halt",   32'(Halted),   32'd1);
        check("p3_addr",   32'(ProgAddr), 32'd2);

        // Countdown loop: LDI 3, SUB 1, JZ 4, JMP 1, HALT.
        fill(8'h80);
        mem[0] = 8'h43; mem[1] = 8'h21; mem[2] = 8'h64; mem[3] = 8'h51; mem[4] = 8'hF0;
        for (int i = 0; i < 8; i++) ch[i] = 32'hDEAD;
        nch = 0;
        start_pulse();
        prev = AccOut;
        cyc  = 0;
        while (!Halted && cyc < 200) begin
            if (AccOut !== prev) begin
                if (nch < 8) ch[nch] = 32'(AccOut);
                nch++;
                prev = AccOut;
            end
            tick();
            cyc++;
        end
        check("p4_cycles", 32'(cyc),      32'd30);
        check("p4_nchg",   32'(nch),      32'd4);
        check("p4_acc0",   ch[0],         32'd3);
        check("p4_acc1",   ch[1],         32'd2);
        check("p4_acc2",   ch[2],         32'd1);
        check("p4_acc3",   ch[3],         32'd0);
        check("p4_addr",   32'(ProgAddr), 32'd4);

        // All NOPs: PC wraps 15 -> 0 and keeps running.
        fill(8'h80);
        start_pulse();
        for (int c = 0; c < 52; c++) begin
            pa_tr[c] = ProgAddr;
            tick();
        end
        check("wrap_pc15", 32'(pa_tr[45]), 32'd15);
        check("wrap_pc0",  32'(pa_tr[48]), 32'd0);
        check("wrap_pc1",  32'(pa_tr[51]), 32'd1);
        check("wrap_busy", 32'(Busy),      32'd1);

        // Reset in the middle of OUTPUT.
        fill(8'h80);
        mem[0] = 8'h49; mem[1] = 8'h70; mem[2] = 8'hF0;
        OutReady = 1'b0;
        Reset    = 1'b1;
        tick();
        Reset = 1'b0;
        start_pulse();
        repeat (8) tick();
        check("ro_valid_pre", 32'(OutValid), 32'd1);
        Reset = 1'b1;
        tick();
        Reset    = 1'b0;
        OutReady = 1'b1;
        check("ro_valid", 32'(OutValid),  32'd0);
        check("ro_data",  32'(OutData),   32'd0);
        check("ro_busy",  32'(Busy),      32'd0);
        check("ro_halt",  32'(Halted),    32'd0);
        check("ro_acc",   32'(AccOut),    32'd0);
        check("ro_addr",  32'(ProgAddr),  32'd0);
        check("ro_aluop", 32'(AluOpcode), 32'h4);

        // Reset in the middle of EXECUTE (LDI 5 would otherwise load Acc).
        fill(8'h80);
        mem[0] = 8'h45; mem[1] = 8'h03; mem[2] = 8'h70; mem[3] = 8'hF0;
        start_pulse();
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("re_acc",  32'(AccOut),   32'd0);
        check("re_busy", 32'(Busy),     32'd0);
        check("re_addr", 32'(ProgAddr), 32'd0);
        tick();
        check("re_idle", 32'(Busy),     32'd0);

        // Start held while busy has no effect.
        start_pulse();
        repeat (4) tick();
        Start = 1'b1;
        repeat (3) tick();
        check("sb_addr", 32'(ProgAddr), 32'd2);
        check("sb_acc",  32'(AccOut),   32'd8);
        Start = 1'b0;
        run_until_halt(cyc, nv, last);
        check("sb_cycles", 32'(cyc),    32'd6);
        check("sb_data",   32'(last),   32'd8);
        check("sb_nvalid", 32'(nv),     32'd1);

        // Start and Reset together from HALTED -> IDLE.
        Start = 1'b1;
        Reset = 1'b1;
        tick();
        Start = 1'b0;
        Reset = 1'b0;
        check("sr_busy", 32'(Busy),   32'd0);
        check("sr_halt", 32'(Halted), 32'd0);
        tick();
        check("sr_idle", 32'(Busy),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller sitting directly upstream of the team ALU (4-bit Opcode, A/B operands, combinational Result).
- Owns PC, instruction register and accumulator (Acc); fetches from an external synchronous-read program memory.
- Drives ALU operands and opcode, captures ALU Result into Acc, and emits values through a valid/ready output port.

Parameters:
- WIDTH, 4: datapath width; must match the ALU WIDTH; also the immediate field width.
- ADDR_WIDTH, 4: PC/program address width; must be ≤ WIDTH; jump target = Imm[ADDR_WIDTH-1:0].

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- Start  in  1  begin execution at PC=0; sampled only in IDLE/HALTED.
- Busy  out  1  high in FETCH/DECODE/EXECUTE/OUTPUT.
- Halted  out  1  high in HALTED.
- ProgAddr  out  ADDR_WIDTH  program memory address (=PC).
- ProgData  in  WIDTH+4  instruction word, valid the cycle after ProgAddr is presented; [WIDTH+3:WIDTH]=Op, [WIDTH-1:0]=Imm.
- AluA  out  WIDTH  ALU operand A.
- AluB  out  WIDTH  ALU operand B.
- AluOpcode  out  4  ALU opcode.
- AluResult  in  WIDTH  ALU result (combinational from AluA/AluB/AluOpcode).
- OutData  out  WIDTH  output value.
- OutValid  out  1  OutData valid.
- OutReady  in  1  consumer accepts when OutValid&&OutReady.
- AccOut  out  WIDTH  accumulator (debug/visibility).

Behaviour:
- Reset (any state, any cycle): state=IDLE, PC=0, IR=0, Acc=0, OutData=0, OutValid=0; Busy=0, Halted=0. Reset overrides Start.
- States: IDLE, FETCH, DECODE, EXECUTE, OUTPUT, HALTED.
- IDLE/HALTED + Start=1 → FETCH with PC=0, Acc=0. Start is ignored in all other states.
- FETCH: ProgAddr=PC → DECODE.
- DECODE: IR ← ProgData → EXECUTE.
- EXECUTE: acts on IR.Op, then moves to FETCH unless noted. Normal instruction = 3 cycles.
- 0x0 ADD: AluA=Acc, AluB=Imm, AluOpcode=0000, Acc ← AluResult.
- 0x1 SHL: AluB=Acc, AluOpcode=0001, Acc ← AluResult.
- 0x2 SUB: AluA=Acc, AluB=Imm, AluOpcode=0010, Acc ← AluResult.
- 0x3 SHR: AluB=Acc, AluOpcode=0011, Acc ← AluResult.
- 0x4 LDI: Acc ← Imm.
- 0x5 JMP: PC ← Imm[ADDR_WIDTH-1:0].
- 0x6 JZ: if Acc==0, PC ← target; else PC ← PC+1.
- 0x7 OUT: OutData ← Acc, OutValid ← 1, → OUTPUT.
- 0xF HALT: → HALTED; PC unchanged.
- Other Op: NOP.
- PC ← PC+1 at end of EXECUTE for every Op except JMP, taken JZ and HALT. PC wraps modulo 2^ADDR_WIDTH (15→0 at ADDR_WIDTH=4).
- OUTPUT: hold OutData/OutValid stable while OutReady=0. On OutValid&&OutReady: OutValid ← 0, PC ← PC+1, → FETCH. Minimum 1 cycle in OUTPUT; OutReady is not looked at before OutValid rises.
- Arithmetic: ALU wraps modulo 2^WIDTH; no carry or flags stored. Zero test uses the current Acc.
- When not in EXECUTE, or for non-ALU ops: AluA=Acc, AluB=0, AluOpcode=4'b0100 (ALU outputs 0). AluResult is ignored.
- AccOut=Acc at all times. Acc changes only in EXECUTE, on Start, or on Reset.
- ProgAddr=PC at all times; memory reads in non-FETCH cycles are harmless.

Test Plan:
- Reset then idle 5 cycles → Busy=0, Halted=0, OutValid=0, ProgAddr=0, AccOut=0, AluOpcode=0100.
- Program 0x45,0x03,0x70,0xF0 (WIDTH=4), Start pulse, OutReady=1 → OutValid=1 with OutData=8 for exactly 1 cycle; Halted=1 thereafter, ProgAddr=3; Start re-runs with an identical trace.
- Program LDI 2, SUB 3, SHR, SHL, HALT → AccOut sequence 2, 0xF, 0x7, 0xE; AluOpcode in the respective EXECUTE cycles 0010, 0011, 0001; each instruction 3 cycles.
- Program LDI 9, OUT, HALT with OutReady=0 for 6 cycles then 1 → OutValid stays high 7 cycles, OutData=9 stable, PC stays 1 until acceptance, then Halted.
- Loop: LDI 3 @0, SUB 1 @1, JZ 4 @2, JMP 1 @3, HALT @4 → Acc 3,2,1,0; JZ taken once; Halted with PC=4. Separately, 16 NOPs → PC wraps 15→0 and execution continues.
- Reset asserted mid-OUTPUT and mid-EXECUTE → next cycle IDLE, all outputs 0. Start asserted while Busy → no effect on PC/Acc. Start and Reset together → IDLE.
